arbiter_merge_2to1: RTL and testbench
=====================================

ARBITER_MERGE_2TO1 -- requirements
Module: arbiter_merge_2to1

Interface
REQ-001 Parameter: DATA_WIDTH, default 32, width of each payload bus.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 i_en  input  1  arbiter enable; low blocks new acceptances.
REQ-005 i_valid_a  input  1  requester A (port 0) holds valid payload.
REQ-006 i_data_a  input  DATA_WIDTH  requester A payload.
REQ-007 o_ready_a  output  1  A payload accepted this cycle when high with i_valid_a.
REQ-008 i_valid_b  input  1  requester B (port 1) holds valid payload.
REQ-009 i_data_b  input  DATA_WIDTH  requester B payload.
REQ-010 o_ready_b  output  1  B payload accepted this cycle when high with i_valid_b.
REQ-011 o_valid  output  1  registered output payload valid.
REQ-012 o_data  output  DATA_WIDTH  registered output payload.
REQ-013 o_grant_b  output  1  source tag of o_data: 0 = A, 1 = B.
REQ-014 i_ready  input  1  downstream accepts o_data when high with o_valid.

Function
REQ-015 Internal register last_b: 1 = B was last served, 0 = A was last served.
REQ-016 Output stage free = (!o_valid) | i_ready, evaluated combinationally each cycle.
REQ-017 Selection sel (combinational): only A valid -> A; only B valid -> B; both valid -> B if last_b == 0, else A.
REQ-018 o_ready_a = i_en & free & i_valid_a & (sel == A); o_ready_b = i_en & free & i_valid_b & (sel == B).
REQ-019 At most one of o_ready_a / o_ready_b shall be high in any cycle.
REQ-020 On acceptance (any ready high): o_data <= selected payload, o_valid <= 1, o_grant_b <= sel, last_b <= sel.
REQ-021 Stage free but no acceptance (no valid inputs, or i_en low): o_valid <= 0; o_data, o_grant_b and last_b hold.
REQ-022 o_valid & !i_ready: o_data, o_grant_b, o_valid and last_b hold; both readies low.
REQ-023 Latency: accepted payload appears on o_data exactly 1 cycle after its acceptance cycle.
REQ-024 Throughput: one acceptance per cycle while i_ready stays high (simultaneous consume and load).
REQ-025 Continuous contention with i_ready high: grants strictly alternate A, B, A, B, ...
REQ-026 Single active requester: served every cycle; last_b updates, so a tie in the following cycle goes to the other port.
REQ-027 i_en deassertion: a pending o_valid payload remains and drains normally via i_ready; no new payload is accepted.
REQ-028 i_valid deasserted by a requester without acceptance: no state change, no fairness penalty.
REQ-029 Payload content is never combined; o_data equals exactly one input payload bit-for-bit.

Reset
REQ-030 rst_n low at a rising edge: o_valid <= 0, o_data <= 0, o_grant_b <= 0, last_b <= 0.
REQ-031 While rst_n is low, o_ready_a and o_ready_b shall be 0.
REQ-032 Reset mid-transfer discards the held payload; first tie after reset grants B.

Verification
REQ-033 Reset, then A=0x11, B=0x22 both valid, i_en=1, i_ready=1 for 4 cycles -> o_data 0x22,0x11,0x22,0x11 with o_grant_b 1,0,1,0, one cycle after each accept.
REQ-034 Only A valid (0xA0..0xA3 across 4 cycles), i_ready=1 -> o_ready_a high every cycle, o_data 0xA0..0xA3, o_grant_b=0, o_ready_b=0.
REQ-035 Load 0x55 from A, then i_ready=0 for 3 cycles with both ports valid -> o_data held 0x55, o_valid=1, both readies 0; on i_ready=1, B is granted next.
REQ-036 Payload held in output, i_en=0, i_ready=1 -> payload consumed, o_valid=0 next cycle, no ready asserted while i_en=0.
REQ-037 rst_n low for one cycle while o_valid=1 with o_data=0x33 -> next cycle o_valid=0, o_data=0, o_grant_b=0; next tie grants B.
REQ-038 Random valid/ready/i_en stimulus for 10k cycles -> scoreboard: no loss, no duplication, per-port order preserved, never both readies high.

Source files
------------

// File: rtl/arbiter_merge_2to1.sv
// Two-input round-robin merge into a single registered output stage.
// A tie between both requesters goes to whichever port was not served last.
module arbiter_merge_2to1 #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_en,
  input  logic                  i_valid_a,
  input  logic [DATA_WIDTH-1:0] i_data_a,
  output logic                  o_ready_a,
  input  logic                  i_valid_b,
  input  logic [DATA_WIDTH-1:0] i_data_b,
  output logic                  o_ready_b,
  output logic                  o_valid,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_grant_b,
  input  logic                  i_ready
);

  logic                  valid_q, valid_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  grant_b_q, grant_b_d;
  logic                  last_b_q, last_b_d;

  logic                  stage_free;
  logic                  sel_b;
  logic                  accept;
  logic [DATA_WIDTH-1:0] sel_data;

  // The output stage can take a new word when empty or being drained this cycle.
  assign stage_free = ~valid_q | i_ready;

  always_comb begin
    if (i_valid_a && i_valid_b) begin
      sel_b = ~last_b_q;
    end else begin
      sel_b = i_valid_b;
    end
  end

  // Readies are forced low while reset is held.
  assign o_ready_a = rst_n & i_en & stage_free & i_valid_a & ~sel_b;
  assign o_ready_b = rst_n & i_en & stage_free & i_valid_b &  sel_b;
  assign accept    = o_ready_a | o_ready_b;

  genvar gi;
  generate
    for (gi = 0; gi < DATA_WIDTH; gi++) begin : g_mux
      assign sel_data[gi] = sel_b ? i_data_b[gi] : i_data_a[gi];
    end
  endgenerate

  always_comb begin
    valid_d   = valid_q;
    data_d    = data_q;
    grant_b_d = grant_b_q;
    last_b_d  = last_b_q;
    if (accept) begin
      valid_d   = 1'b1;
      data_d    = sel_data;
      grant_b_d = sel_b;
      last_b_d  = sel_b;
    end else if (stage_free) begin
      valid_d   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q   <= 1'b0;
      data_q    <= '0;
      grant_b_q <= 1'b0;
      last_b_q  <= 1'b0;
    end else begin
      valid_q   <= valid_d;
      data_q    <= data_d;
      grant_b_q <= grant_b_d;
      last_b_q  <= last_b_d;
    end
  end

  assign o_valid   = valid_q;
  assign o_data    = data_q;
  assign o_grant_b = grant_b_q;

endmodule

// File: tb/tb_arbiter_merge_2to1.sv
// Bench for arbiter_merge_2to1: directed scenario tasks plus a free-running
// reference model whose scoreboard queue tracks every accepted payload.
module tb_arbiter_merge_2to1;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          i_en;
  logic          i_valid_a, i_valid_b;
  logic [DW-1:0] i_data_a, i_data_b;
  logic          o_ready_a, o_ready_b;
  logic          o_valid;
  logic [DW-1:0] o_data;
  logic          o_grant_b;
  logic          i_ready;

  int n_cmp = 0;
  int n_bad = 0;

  logic [DW:0] exp_q[$];
  logic        m_valid  = 1'b0;
  logic        m_last_b = 1'b0;
  bit          mon_en   = 1'b0;

  always #5 clk = ~clk;

  arbiter_merge_2to1 #(.DATA_WIDTH(DW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_en      (i_en),
    .i_valid_a (i_valid_a),
    .i_data_a  (i_data_a),
    .o_ready_a (o_ready_a),
    .i_valid_b (i_valid_b),
    .i_data_b  (i_data_b),
    .o_ready_b (o_ready_b),
    .o_valid   (o_valid),
    .o_data    (o_data),
    .o_grant_b (o_grant_b),
    .i_ready   (i_ready)
  );

  // Reference model: predicts readies, pushes accepted words, pops on consume.
  always @(negedge clk) begin : monitor
    logic        free, sel_b, exp_ra, exp_rb;
    logic [DW:0] head;
    if (mon_en) begin
      free   = !m_valid || i_ready;
      sel_b  = (i_valid_a && i_valid_b) ? !m_last_b : i_valid_b;
      exp_ra = rst_n && i_en && free && i_valid_a && !sel_b;
      exp_rb = rst_n && i_en && free && i_valid_b && sel_b;
      n_cmp++;
      if ({o_ready_a, o_ready_b} !== {exp_ra, exp_rb}) begin
        n_bad++;
        $display("FAIL mon_ready t=%0t got a=%b b=%b want a=%b b=%b", $time, o_ready_a, o_ready_b, exp_ra, exp_rb);
      end
      n_cmp++;
      if (o_ready_a === 1'b1 && o_ready_b === 1'b1) begin
        n_bad++;
        $display("FAIL mon_exclusive t=%0t got both readies high want at most one", $time);
      end
      n_cmp++;
      if (o_valid !== m_valid) begin
        n_bad++;
        $display("FAIL mon_valid t=%0t got %b want %b", $time, o_valid, m_valid);
      end
      if (m_valid) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_bad++;
          $display("FAIL mon_queue t=%0t got output word want none pending", $time);
        end else begin
          head = exp_q[0];
          if ({o_grant_b, o_data} !== head) begin
            n_bad++;
            $display("FAIL mon_data t=%0t got tag=%b data=%h want tag=%b data=%h",
                     $time, o_grant_b, o_data, head[DW], head[DW-1:0]);
          end
          if (i_ready && rst_n) begin
            $display("xfer t=%0t port=%s data=%h", $time, head[DW] ? "B" : "A", head[DW-1:0]);
            void'(exp_q.pop_front());
          end
        end
      end
      if (!rst_n) begin
        m_valid  = 1'b0;
        m_last_b = 1'b0;
        exp_q.delete();
      end else if (exp_ra || exp_rb) begin
        exp_q.push_back(sel_b ? {1'b1, i_data_b} : {1'b0, i_data_a});
        m_valid  = 1'b1;
        m_last_b = sel_b;
      end else if (free) begin
        m_valid = 1'b0;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; i_en = 1'b1; i_ready = 1'b1;
    i_valid_a = 1'b1; i_valid_b = 1'b1;
    i_data_a = 32'hDEAD0001; i_data_b = 32'hDEAD0002;
    repeat (2) step();
    @(negedge clk);
    n_cmp++;
    if ({o_ready_a, o_ready_b} !== 2'b00) begin
      n_bad++;
      $display("FAIL reset_ready got a=%b b=%b want 0 0", o_ready_a, o_ready_b);
    end
    step();
    n_cmp++;
    if (o_valid !== 1'b0 || o_data !== '0 || o_grant_b !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_state got v=%b d=%h g=%b want 0 0 0", o_valid, o_data, o_grant_b);
    end
    i_valid_a = 1'b0; i_valid_b = 1'b0;
    rst_n = 1'b1;
    mon_en = 1'b1;
  endtask

  task automatic test_contention();
    logic exp_b;
    i_data_a = 32'h11; i_data_b = 32'h22;
    i_valid_a = 1'b1; i_valid_b = 1'b1; i_en = 1'b1; i_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      exp_b = (k % 2 == 0);
      @(negedge clk);
      n_cmp++;
      if (o_ready_b !== exp_b || o_ready_a !== !exp_b) begin
        n_bad++;
        $display("FAIL contention_ready k=%0d got a=%b b=%b want b=%b", k, o_ready_a, o_ready_b, exp_b);
      end
      step();
      n_cmp++;
      if (o_valid !== 1'b1 || o_grant_b !== exp_b || o_data !== (exp_b ? 32'h22 : 32'h11)) begin
        n_bad++;
        $display("FAIL contention_out k=%0d got v=%b g=%b d=%h want g=%b", k, o_valid, o_grant_b, o_data, exp_b);
      end
    end
    i_valid_a = 1'b0; i_valid_b = 1'b0;
    step();
  endtask

  task automatic test_single_a();
    logic [DW-1:0] exp_d;
    i_valid_a = 1'b1; i_ready = 1'b1; i_en = 1'b1;
    for (int k = 0; k < 4; k++) begin
      exp_d = 32'hA0 + 32'(k);
      i_data_a = exp_d;
      @(negedge clk);
      n_cmp++;
      if (o_ready_a !== 1'b1 || o_ready_b !== 1'b0) begin
        n_bad++;
        $display("FAIL single_a_ready k=%0d got a=%b b=%b want 1 0", k, o_ready_a, o_ready_b);
      end
      step();
      n_cmp++;
      if (o_data !== exp_d || o_grant_b !== 1'b0 || o_valid !== 1'b1) begin
        n_bad++;
        $display("FAIL single_a_out k=%0d got d=%h g=%b want d=%h g=0", k, o_data, o_grant_b, exp_d);
      end
    end
    i_valid_b = 1'b1; i_data_b = 32'hB0;
    @(negedge clk);
    n_cmp++;
    if (o_ready_b !== 1'b1 || o_ready_a !== 1'b0) begin
      n_bad++;
      $display("FAIL single_a_tie got a=%b b=%b want 0 1", o_ready_a, o_ready_b);
    end
    step();
    i_valid_a = 1'b0; i_valid_b = 1'b0;
    step();
  endtask

  task automatic test_backpressure();
    i_valid_a = 1'b1; i_data_a = 32'h55; i_ready = 1'b1;
    step();
    i_ready = 1'b0; i_data_a = 32'h66; i_valid_b = 1'b1; i_data_b = 32'h77;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      n_cmp++;
      if ({o_ready_a, o_ready_b} !== 2'b00 || o_valid !== 1'b1 || o_data !== 32'h55 || o_grant_b !== 1'b0) begin
        n_bad++;
        $display("FAIL backpressure_hold k=%0d got ra=%b rb=%b v=%b d=%h g=%b want 0 0 1 55 0",
                 k, o_ready_a, o_ready_b, o_valid, o_data, o_grant_b);
      end
      step();
    end
    i_ready = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (o_ready_b !== 1'b1 || o_ready_a !== 1'b0) begin
      n_bad++;
      $display("FAIL backpressure_release got a=%b b=%b want 0 1", o_ready_a, o_ready_b);
    end
    step();
    n_cmp++;
    if (o_data !== 32'h77 || o_grant_b !== 1'b1) begin
      n_bad++;
      $display("FAIL backpressure_out got d=%h g=%b want 77 1", o_data, o_grant_b);
    end
    i_valid_a = 1'b0; i_valid_b = 1'b0;
    step();
  endtask

  task automatic test_enable();
    i_valid_a = 1'b1; i_data_a = 32'h44; i_ready = 1'b1; i_en = 1'b1;
    step();
    i_en = 1'b0; i_valid_b = 1'b1; i_data_b = 32'h45; i_data_a = 32'h46;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      n_cmp++;
      if ({o_ready_a, o_ready_b} !== 2'b00) begin
        n_bad++;
        $display("FAIL enable_ready k=%0d got a=%b b=%b want 0 0", k, o_ready_a, o_ready_b);
      end
      step();
      n_cmp++;
      if (o_valid !== 1'b0 || o_data !== 32'h44) begin
        n_bad++;
        $display("FAIL enable_drain k=%0d got v=%b d=%h want 0 44", k, o_valid, o_data);
      end
    end
    i_en = 1'b1; i_valid_a = 1'b0; i_valid_b = 1'b0;
  endtask

  task automatic test_reset_mid();
    i_valid_b = 1'b1; i_data_b = 32'h33; i_ready = 1'b1;
    step();
    i_ready = 1'b0; i_valid_b = 1'b0;
    step();
    n_cmp++;
    if (o_valid !== 1'b1 || o_data !== 32'h33 || o_grant_b !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_mid_load got v=%b d=%h g=%b want 1 33 1", o_valid, o_data, o_grant_b);
    end
    rst_n = 1'b0; i_ready = 1'b1; i_valid_a = 1'b1; i_valid_b = 1'b1;
    i_data_a = 32'h34; i_data_b = 32'h35;
    step();
    n_cmp++;
    if (o_valid !== 1'b0 || o_data !== '0 || o_grant_b !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_mid_clear got v=%b d=%h g=%b want 0 0 0", o_valid, o_data, o_grant_b);
    end
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (o_ready_b !== 1'b1 || o_ready_a !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_mid_tie got a=%b b=%b want 0 1", o_ready_a, o_ready_b);
    end
    step();
    n_cmp++;
    if (o_data !== 32'h35 || o_grant_b !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_mid_out got d=%h g=%b want 35 1", o_data, o_grant_b);
    end
    i_valid_a = 1'b0; i_valid_b = 1'b0;
    step();
  endtask

  task automatic test_random();
    logic [15:0] seq_a = '0;
    logic [15:0] seq_b = '0;
    for (int c = 0; c < 10000; c++) begin
      i_en      = ($urandom_range(0, 9) != 0);
      i_ready   = ($urandom_range(0, 3) != 0);
      i_valid_a = ($urandom_range(0, 1) == 1);
      i_valid_b = ($urandom_range(0, 1) == 1);
      i_data_a  = {16'hAAAA, seq_a};
      i_data_b  = {16'hBBBB, seq_b};
      @(negedge clk);
      if (o_ready_a === 1'b1 && i_valid_a) seq_a++;
      if (o_ready_b === 1'b1 && i_valid_b) seq_b++;
      step();
    end
    i_valid_a = 1'b0; i_valid_b = 1'b0; i_ready = 1'b1; i_en = 1'b1;
    repeat (3) step();
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL random_drain got %0d words pending want 0", exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_contention();
    test_single_a();
    test_backpressure();
    test_enable();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
